// File: rtl/rr_select_mux_if.sv
// Handshake and data bundle for rr_select_mux.
// The producer/consumer side uses master; the selector uses slave.
interface rr_select_mux_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int ADDR_W = $clog2(CHANNELS);

    logic                      mode;
    logic [ADDR_W-1:0]         address;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [ADDR_W-1:0]         out_channel;
    logic                      out_ready;

    modport master (
        output mode, address, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_channel
    );

    modport slave (
        input  mode, address, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_channel
    );
endinterface

// File: rtl/rr_select_mux.sv
// Registered N-channel selector with a one-entry valid/ready output stage.
// Mode 0 arbitrates round-robin from a rotating pointer; mode 1 takes only
// the addressed channel. The pointer advances past every granted channel.
module rr_select_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic          clk,
    input  logic          reset,
    rr_select_mux_if.slave bus
);
    localparam int ADDR_W = $clog2(CHANNELS);

    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] scan_idx;
    logic [ADDR_W-1:0] grant_idx;
    logic              grant_found;
    logic              load_en;
    logic              load;
    logic [WIDTH-1:0]  sel_data;

    logic              out_valid_q;
    logic [WIDTH-1:0]  out_data_q;
    logic [ADDR_W-1:0] out_channel_q;

    // Grant search: addressed channel only, or first requester from ptr onward.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        if (bus.mode) begin
            if (bus.in_valid[bus.address]) begin
                grant_found = 1'b1;
                grant_idx   = bus.address;
            end
        end else begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                // Power-of-two channel count makes the index wrap for free.
                scan_idx = ptr + ADDR_W'(k);
                if (!grant_found && bus.in_valid[scan_idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = scan_idx;
                end
            end
        end
    end

    assign load_en = !out_valid_q || bus.out_ready;
    assign load    = load_en && grant_found && !reset;

    // One-hot acknowledge to the granted channel only when the word is taken.
    always_comb begin
        bus.in_ready = '0;
        if (load) begin
            bus.in_ready[grant_idx] = 1'b1;
        end
    end

    // Data mux keyed on the grant index; in_data never reaches a handshake output.
    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (grant_idx == ADDR_W'(k)) begin
                sel_data = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output register and round-robin pointer: load, drain, or hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
            ptr           <= '0;
        end else if (load) begin
            out_valid_q   <= 1'b1;
            out_data_q    <= sel_data;
            out_channel_q <= grant_idx;
            ptr           <= grant_idx + ADDR_W'(1);
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q   <= 1'b0;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_channel = out_channel_q;
endmodule

// File: tb/tb_rr_select_mux.sv
// Self-checking bench for rr_select_mux: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_rr_select_mux;
    localparam int N = 4;
    localparam int W = 8;

    logic clk;
    logic reset;
    logic [W-1:0] dw [N];

    int checks;
    int errors;

    rr_select_mux_if #(.WIDTH(W), .CHANNELS(N)) bus ();

    rr_select_mux #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.in_data = {dw[3], dw[2], dw[1], dw[0]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    typedef struct {
        bit         mode;
        int         addr;
        logic [3:0] iv;
        bit         ordy;
        logic [3:0] exp_ready;
        bit         exp_v;
        int         exp_ch;
        logic [7:0] exp_d;
    } vec_t;

    vec_t tbl[$];

    // Behavioural reference state
    bit         m_valid;
    logic [7:0] m_data;
    int         m_ch;
    int         m_ptr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input bit mode, input int addr, input logic [3:0] iv, input bit ordy,
                       input logic [3:0] er, input bit ev, input int ech, input logic [7:0] ed);
        vec_t v;
        v.mode = mode; v.addr = addr; v.iv = iv; v.ordy = ordy;
        v.exp_ready = er; v.exp_v = ev; v.exp_ch = ech; v.exp_d = ed;
        tbl.push_back(v);
    endtask

    // Closest requester at or after ptr in circular distance, or the address in mode 1.
    function automatic int ref_grant(input bit mode, input int addr, input logic [3:0] iv, input int ptr);
        int best;
        int bestd;
        int d;
        if (mode) return iv[addr] ? addr : -1;
        best = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            d = (i - ptr + N) % N;
            if (iv[i] && d < bestd) begin
                best = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    task automatic drive(input bit mode, input int addr, input logic [3:0] iv, input bit ordy);
        bus.mode      = mode;
        bus.address   = 2'(addr);
        bus.in_valid  = iv;
        bus.out_ready = ordy;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        for (int i = 0; i < N; i++) dw[i] = 8'hA0 + 8'(i);
        drive(0, 0, 4'b1111, 1);

        // Reset then idle
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_channel", bus.out_channel, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 4'b0000, 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("idle_out_valid", bus.out_valid, 0);
        end

        // Directed table, starting from the empty post-reset state with ptr=0
        add(0, 0, 4'b1111, 1, 4'b0001, 1, 0, 8'hA0);
        add(0, 0, 4'b1111, 1, 4'b0010, 1, 1, 8'hA1);
        add(0, 0, 4'b1111, 1, 4'b0100, 1, 2, 8'hA2);
        add(0, 0, 4'b1111, 1, 4'b1000, 1, 3, 8'hA3);
        add(0, 0, 4'b1111, 1, 4'b0001, 1, 0, 8'hA0);
        add(0, 0, 4'b0100, 1, 4'b0100, 1, 2, 8'hA2);
        add(0, 0, 4'b0011, 1, 4'b0001, 1, 0, 8'hA0);
        add(0, 0, 4'b0011, 1, 4'b0010, 1, 1, 8'hA1);
        add(1, 2, 4'b1011, 1, 4'b0000, 0, 1, 8'hA1);
        add(1, 2, 4'b1011, 1, 4'b0000, 0, 1, 8'hA1);
        add(1, 2, 4'b1111, 1, 4'b0100, 1, 2, 8'hA2);
        add(0, 0, 4'b1111, 0, 4'b0000, 1, 2, 8'hA2);
        add(0, 0, 4'b1111, 0, 4'b0000, 1, 2, 8'hA2);
        add(0, 0, 4'b1111, 1, 4'b1000, 1, 3, 8'hA3);
        add(0, 0, 4'b0000, 0, 4'b0000, 1, 3, 8'hA3);
        add(0, 0, 4'b0000, 1, 4'b0000, 0, 3, 8'hA3);
        add(0, 0, 4'b0000, 1, 4'b0000, 0, 3, 8'hA3);
        add(0, 0, 4'b0001, 0, 4'b0001, 1, 0, 8'hA0);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].mode, tbl[i].addr, tbl[i].iv, tbl[i].ordy);
            #2;
            check($sformatf("tbl%0d_in_ready", i), bus.in_ready, tbl[i].exp_ready);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].exp_v);
            check($sformatf("tbl%0d_out_channel", i), bus.out_channel, tbl[i].exp_ch);
            check($sformatf("tbl%0d_out_data", i), bus.out_data, tbl[i].exp_d);
            @(negedge clk);
        end

        // Fixed select: addressed channel idle means no grant at all
        pulse_reset();
        dw[2] = 8'h5C;
        drive(1, 2, 4'b1011, 1);
        for (int c = 0; c < 2; c++) begin
            #2;
            check("fix_in_ready_none", bus.in_ready, 0);
            @(posedge clk);
            #1;
            check("fix_out_valid_none", bus.out_valid, 0);
            @(negedge clk);
        end
        drive(1, 2, 4'b1111, 1);
        #2;
        check("fix_in_ready", bus.in_ready, 4'b0100);
        @(posedge clk);
        #1;
        check("fix_out_data", bus.out_data, 8'h5C);
        check("fix_out_channel", bus.out_channel, 2);

        // Backpressure: hold 8'h11 from ch1 for three cycles, then drain+reload
        @(negedge clk);
        dw[1] = 8'h11;
        drive(1, 1, 4'b0010, 1);
        @(posedge clk);
        #1;
        check("bp_load_data", bus.out_data, 8'h11);
        @(negedge clk);
        drive(0, 0, 4'b1111, 0);
        for (int c = 0; c < 3; c++) begin
            #2;
            check("bp_in_ready_hold", bus.in_ready, 0);
            @(posedge clk);
            #1;
            check("bp_out_data_hold", bus.out_data, 8'h11);
            check("bp_out_valid_hold", bus.out_valid, 1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #2;
        check("bp_release_in_ready", bus.in_ready, 4'b0100);
        @(posedge clk);
        #1;
        check("bp_release_valid", bus.out_valid, 1);
        check("bp_release_data", bus.out_data, 8'h5C);

        // Asynchronous reset with a word held under backpressure
        @(negedge clk);
        drive(0, 0, 4'b1111, 0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_out_data", bus.out_data, 0);
        check("arst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 4'b1111, 1);
        #2;
        check("arst_first_grant", bus.in_ready, 4'b0001);
        @(posedge clk);
        #1;
        check("arst_first_channel", bus.out_channel, 0);

        // Randomized traffic against the reference model
        pulse_reset();
        m_valid = 0; m_data = '0; m_ch = 0; m_ptr = 0;
        for (int c = 0; c < 400; c++) begin
            bit         rm;
            int         ra;
            logic [3:0] riv;
            bit         rr;
            int         g;
            bit         ld;
            logic [3:0] er;
            rm  = ($urandom_range(0, 3) == 0);
            ra  = $urandom_range(0, N - 1);
            riv = 4'($urandom_range(0, 15));
            rr  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) dw[i] = 8'($urandom);
            drive(rm, ra, riv, rr);
            g  = ref_grant(rm, ra, riv, m_ptr);
            ld = (!m_valid || rr) && (g >= 0);
            er = ld ? 4'(1 << g) : 4'b0000;
            #2;
            check("rnd_in_ready", bus.in_ready, er);
            if (ld) begin
                m_valid = 1;
                m_data  = dw[g];
                m_ch    = g;
                m_ptr   = (g + 1) % N;
            end else if (m_valid && rr) begin
                m_valid = 0;
            end
            @(posedge clk);
            #1;
            check("rnd_out_valid", bus.out_valid, m_valid);
            check("rnd_out_data", bus.out_data, m_data);
            check("rnd_out_channel", bus.out_channel, m_ch);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
